cmp_serial_nbit: RTL and testbench

// - Parametrised magnitude comparator for WIDTH-bit operands; returns equal / less-than / greater-than flags.
// - Compares MSB-first, DIGIT bits per cycle, and stops at the first differing digit.
// - Supports unsigned and two's-complement signed compare, selected per operation.
// - Uses a start/busy/done handshake so arithmetic and sort datapaths can share one small comparator.
//

---
 rtl/cmp_serial_nbit.sv | 110 +++++++++++
 tb/tb_cmp_serial_nbit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cmp_serial_nbit.sv
// Serial MSB-first magnitude comparator: DIGIT bits per cycle, early exit on
// the first differing digit, unsigned or two's-complement per operation.
module cmp_serial_nbit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_TOP  = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] opa, opb, opa_nx, opb_nx;
    logic             eq_nx, lt_nx, gt_nx;
    logic [DIGIT-1:0] da, db;
    logic             accept;

    // Digit currently under examination, most significant first
    always_comb begin
        da = opa[cnt*DIGIT +: DIGIT];
        db = opb[cnt*DIGIT +: DIGIT];
    end

    // Next-state, capture and result logic
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        opa_nx   = opa;
        opb_nx   = opb;
        eq_nx    = eq;
        lt_nx    = lt;
        gt_nx    = gt;
        accept   = start && (state != S_CMP);

        case (state)
            S_IDLE, S_DONE: begin
                state_nx = S_IDLE;
                if (accept) begin
                    // Flipping the sign bit maps two's-complement order onto unsigned order
                    opa_nx   = signed_mode ? (a ^ MSB_MASK) : a;
                    opb_nx   = signed_mode ? (b ^ MSB_MASK) : b;
                    cnt_nx   = CNT_TOP;
                    state_nx = S_CMP;
                end
            end
            S_CMP: begin
                if (da != db) begin
                    eq_nx    = 1'b0;
                    lt_nx    = (da < db);
                    gt_nx    = (da > db);
                    state_nx = S_DONE;
                end else if (cnt == '0) begin
                    eq_nx    = 1'b1;
                    lt_nx    = 1'b0;
                    gt_nx    = 1'b0;
                    state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, operand and registered output flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            eq    <= 1'b1;
            lt    <= 1'b0;
            gt    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            opa   <= opa_nx;
            opb   <= opb_nx;
            busy  <= (state_nx == S_CMP);
            done  <= (state_nx == S_DONE);
            eq    <= eq_nx;
            lt    <= lt_nx;
            gt    <= gt_nx;
        end
    end

endmodule

// File: tb/tb_cmp_serial_nbit.sv
// Scoreboard bench for cmp_serial_nbit: 16/4 and 8/1 instances.
module tb_cmp_serial_nbit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0, sm0;
    logic [15:0] a0, b0;
    logic        busy0, done0, eq0, lt0, gt0;
    logic        start1, sm1;
    logic [7:0]  a1, b1;
    logic        busy1, done1, eq1, lt1, gt1;

    cmp_serial_nbit #(.WIDTH(16), .DIGIT(4)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .signed_mode(sm0),
        .busy(busy0), .done(done0), .eq(eq0), .lt(lt0), .gt(gt0)
    );

    cmp_serial_nbit #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .signed_mode(sm1),
        .busy(busy1), .done(done1), .eq(eq1), .lt(lt1), .gt(gt1)
    );

    typedef struct {
        logic [2:0] res;   // {eq, lt, gt}
        int         lat;
        int         c0;
        string      name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Monitor for the 16-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done0) begin
            if (q0.size() == 0) chk("unexpected_done0", 1, 0);
            else begin
                e = q0.pop_front();
                chk({e.name, "_res"}, int'({eq0, lt0, gt0}), int'(e.res));
                chk({e.name, "_lat"}, cyc - e.c0, e.lat);
            end
        end
    end

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done1) begin
            if (q1.size() == 0) chk("unexpected_done1", 1, 0);
            else begin
                e = q1.pop_front();
                chk({e.name, "_res"}, int'({eq1, lt1, gt1}), int'(e.res));
                chk({e.name, "_lat"}, cyc - e.c0, e.lat);
            end
        end
    end

    task automatic drive(input int d, input logic st, input logic [15:0] a, input logic [15:0] b,
                         input logic s);
        if (d == 0) begin start0 = st; a0 = a; b0 = b; sm0 = s; end
        else begin start1 = st; a1 = a[7:0]; b1 = b[7:0]; sm1 = s; end
    endtask

    // One operation; optionally pokes an ignored start while busy
    task automatic run_op(input int d, input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [2:0] res, input int lat, input bit poke);
        exp_t e;
        int   t;
        int   nb;
        bit   fin;
        @(negedge clk);
        t = 0;
        while (((d == 0) ? busy0 : busy1) && t < 100) begin @(negedge clk); t++; end
        drive(d, 1'b1, a, b, s);
        @(posedge clk);
        #1;
        e.res = res; e.lat = lat; e.c0 = cyc; e.name = name;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        drive(d, 1'b0, ~a, ~b, ~s);
        nb = 0; t = 0; fin = 0;
        while (!fin && t < 200) begin
            @(negedge clk);
            t++;
            if ((d == 0) ? done0 : done1) fin = 1;
            else begin
                if ((d == 0) ? busy0 : busy1) nb++;
                if (poke && nb == 1) drive(d, 1'b1, 16'h0000, 16'hFFFF, 1'b0);
                else drive(d, 1'b0, ~a, ~b, ~s);
            end
        end
        chk({name, "_finished"}, int'(fin), 1);
        chk({name, "_busy_cycles"}, nb, lat);
    endtask

    initial begin
        exp_t e;
        int   t;
        rst = 1'b1;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_flags", int'({eq0, lt0, gt0}), 3'b100);
        chk("rst_flags8", int'({busy1, done1, eq1, lt1, gt1}), 5'b00100);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_hold", int'({busy0, done0, eq0, lt0, gt0}), 5'b00100);
        end

        run_op(0, "eq_1234",     16'h1234, 16'h1234, 1'b0, 3'b100, 4, 1'b1);
        run_op(0, "u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 3'b001, 1, 1'b0);
        run_op(0, "s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 3'b010, 1, 1'b0);
        run_op(0, "u_12f0_12e0", 16'h12F0, 16'h12E0, 1'b0, 3'b001, 3, 1'b1);
        run_op(0, "u_0100_0010", 16'h0100, 16'h0010, 1'b0, 3'b001, 2, 1'b0);
        run_op(0, "s_ffff_0001", 16'hFFFF, 16'h0001, 1'b1, 3'b010, 1, 1'b0);
        repeat (5) @(negedge clk);
        chk("hold_after_ignored", int'({eq0, lt0, gt0}), 3'b010);

        // Back-to-back: start held high, new operands presented in DONE
        @(negedge clk);
        drive(0, 1'b1, 16'h0005, 16'h0003, 1'b0);
        @(posedge clk);
        #1;
        e.res = 3'b001; e.lat = 4; e.c0 = cyc; e.name = "b2b_first";
        q0.push_back(e);
        t = 0;
        do begin @(negedge clk); t++; end while (!done0 && t < 50);
        chk("b2b_first_done", int'(done0), 1);
        drive(0, 1'b1, 16'hA000, 16'hB000, 1'b0);
        @(posedge clk);
        #1;
        e.res = 3'b010; e.lat = 1; e.c0 = cyc; e.name = "b2b_second";
        q0.push_back(e);
        chk("b2b_no_gap_busy", int'(busy0), 1);
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        t = 0;
        do begin @(negedge clk); t++; end while (!done0 && t < 50);
        chk("b2b_second_done", int'(done0), 1);

        // Reset mid-operation on equal operands
        @(negedge clk);
        drive(0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk("mid_busy_before_rst", int'(busy0), 1);
        chk("mid_flags_before_rst", int'({eq0, lt0, gt0}), 3'b010);
        rst = 1'b1;
        #1;
        chk("mid_rst_state", int'({busy0, done0, eq0, lt0, gt0}), 5'b00100);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_state", int'({busy0, done0, eq0, lt0, gt0}), 5'b00100);

        // Bit-serial 8-bit instance
        run_op(1, "w8_s_fe_ff", 16'h00FE, 16'h00FF, 1'b1, 3'b010, 8, 1'b1);
        run_op(1, "w8_s_ff_80", 16'h00FF, 16'h0080, 1'b1, 3'b001, 2, 1'b0);
        run_op(1, "w8_u_5a_5a", 16'h005A, 16'h005A, 1'b0, 3'b100, 8, 1'b0);

        repeat (4) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
